game_field_editor: RTL

GAME_FIELD_EDITOR -- requirements
Module: game_field_editor

---
 rtl/game_field_editor_pkg.sv | 27 ++
 rtl/game_field_editor_key_edge.sv | 24 ++
 rtl/game_field_editor.sv | 139 +++++++++++++
 3 files changed

// File: rtl/game_field_editor_pkg.sv
// Shared game configuration: field geometry, cursor widths, editor FSM states.
// No logic; constants and types only.
// Imported by the editor and its key edge detectors.
package game_field_editor_pkg;

    // Field geometry: cells per row and number of rows.
    localparam int FIELD_W = 40;
    localparam int FIELD_H = 30;

    // Cursor coordinate widths; must cover FIELD_W-1 and FIELD_H-1.
    localparam int X_W = 6;
    localparam int Y_W = 5;

    // Editor FSM encoding.
    typedef logic [1:0] state_t;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EDIT   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    // One-cycle key events after edge detection.
    typedef struct packed {
        logic left;
        logic right;
        logic toggle;
    } key_evt_t;

endpackage

// File: rtl/game_field_editor_key_edge.sv
// Rising-edge detector for one raw key level; pulse is high for one cycle per 0->1.
// Latency: pulse is combinational from key against the registered previous level.
// No backpressure; every rising edge yields exactly one pulse.
module game_key_edge (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic pulse
);

    logic key_q;

    // Remember last cycle's level; cleared on reset so a level held through release counts once.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q <= 1'b0;
        end else begin
            key_q <= key;
        end
    end

    assign pulse = key & ~key_q;

endmodule

// File: rtl/game_field_editor.sv
// Game field editor: loads the field, moves a cursor and flips cells, then strobes the result out.
// Latency: key events act on the edge they are sampled; field_out_vld one cycle after edit_en drops.
// No backpressure; field_out_vld is a single-cycle strobe that the field register must accept.
module game_field_editor #(
    parameter int FIELD_W = game_field_editor_pkg::FIELD_W,
    parameter int FIELD_H = game_field_editor_pkg::FIELD_H
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 edit_en,
    input  logic                                 key_left,
    input  logic                                 key_right,
    input  logic                                 key_toggle,
    input  logic [FIELD_W-1:0]                   field_in [FIELD_H],
    output logic [FIELD_W-1:0]                   field_out [FIELD_H],
    output logic                                 field_out_vld,
    output logic [game_field_editor_pkg::X_W-1:0] cursor_x,
    output logic [game_field_editor_pkg::Y_W-1:0] cursor_y,
    output logic                                 editing
);

    import game_field_editor_pkg::*;

    localparam logic [X_W-1:0] X_MAX = X_W'(FIELD_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(FIELD_H - 1);

    state_t             state;
    key_evt_t           evt;
    logic [FIELD_W-1:0] field_buf [FIELD_H];
    logic [X_W-1:0]     x_next;
    logic [Y_W-1:0]     y_next;
    logic [X_W-1:0]     flip_bit;
    logic               in_edit;

    game_key_edge u_edge_left (
        .clk   (clk),
        .rst   (rst),
        .key   (key_left),
        .pulse (evt.left)
    );

    game_key_edge u_edge_right (
        .clk   (clk),
        .rst   (rst),
        .key   (key_right),
        .pulse (evt.right)
    );

    game_key_edge u_edge_toggle (
        .clk   (clk),
        .rst   (rst),
        .key   (key_toggle),
        .pulse (evt.toggle)
    );

    // Edits only happen while staying in EDIT; the cycle edit_en drops ignores keys.
    assign in_edit = (state == ST_EDIT) && edit_en;

    // Column 0 is the MSB, so the flipped bit index mirrors the cursor column.
    assign flip_bit = X_MAX - cursor_x;

    // Next cursor position: both arrows together step down a row, otherwise step left/right with wrap.
    always_comb begin
        x_next = cursor_x;
        y_next = cursor_y;
        if (evt.left && evt.right) begin
            y_next = (cursor_y == Y_MAX) ? '0 : cursor_y + 1'b1;
        end else if (evt.left) begin
            x_next = (cursor_x == '0) ? X_MAX : cursor_x - 1'b1;
        end else if (evt.right) begin
            x_next = (cursor_x == X_MAX) ? '0 : cursor_x + 1'b1;
        end
    end

    // Editor FSM with registered mode outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            editing       <= 1'b0;
            field_out_vld <= 1'b0;
        end else begin
            field_out_vld <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (edit_en) begin
                        state   <= ST_EDIT;
                        editing <= 1'b1;
                    end
                end
                ST_EDIT: begin
                    if (!edit_en) begin
                        state         <= ST_COMMIT;
                        editing       <= 1'b0;
                        field_out_vld <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    editing <= 1'b0;
                end
            endcase
        end
    end

    // Cursor: homed on entry to EDIT, moved only by events while staying in EDIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cursor_x <= '0;
            cursor_y <= '0;
        end else if (state == ST_IDLE && edit_en) begin
            cursor_x <= '0;
            cursor_y <= '0;
        end else if (in_edit) begin
            cursor_x <= x_next;
            cursor_y <= y_next;
        end
    end

    // Edit buffer: snapshot of field_in on entry, cell flips at the pre-move cursor, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < FIELD_H; r++) begin
                field_buf[r] <= '0;
            end
        end else if (state == ST_IDLE && edit_en) begin
            for (int r = 0; r < FIELD_H; r++) begin
                field_buf[r] <= field_in[r];
            end
        end else if (in_edit && evt.toggle) begin
            field_buf[cursor_y][flip_bit] <= ~field_buf[cursor_y][flip_bit];
        end
    end

    assign field_out = field_buf;

endmodule
